// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 8-bit Adder among NREQ requesters; it grants one
// request at a time and returns the registered 9-bit result with the owner ID.
// Ports: iClk, iRst_n (async, active low), iReq/iSA/iData_a/iData_b (per
// requester), oGnt (one-hot pulse), oValid/iReady result handshake,
// oData/oData_C (registered Adder outputs), oId (owner), oBusy (FSM not idle).
// Option: define ADDER_ARB_RR_EN for round-robin; otherwise lowest index wins.

// Adder: 9-bit exact sum of two 8-bit operands; iSA=1 treats them as signed.
// oData_C is the carry out of the raw 8-bit addition.
module Adder (
  input  logic       iSA,
  input  logic [7:0] iData_a,
  input  logic [7:0] iData_b,
  output logic [8:0] oData,
  output logic       oData_C
);
  logic [8:0] ext_a;
  logic [8:0] ext_b;

  assign ext_a = {iSA & iData_a[7], iData_a};
  assign ext_b = {iSA & iData_b[7], iData_b};
  assign oData = ext_a + ext_b;

  // oData[7] is the 8-bit sum bit 7 in both modes; when a7^b7 the
  // carry into bit 7 is its inverse, which then becomes the carry out.
  assign oData_C = (iData_a[7] & iData_b[7]) |
                   ((iData_a[7] ^ iData_b[7]) & ~oData[7]);
endmodule

module adder_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [NREQ-1:0]   iReq,
  input  logic [NREQ-1:0]   iSA,
  input  logic [8*NREQ-1:0] iData_a,
  input  logic [8*NREQ-1:0] iData_b,
  output logic [NREQ-1:0]   oGnt,
  output logic              oValid,
  input  logic              iReady,
  output logic [8:0]        oData,
  output logic              oData_C,
  output logic [ID_W-1:0]   oId,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              sa_q, sa_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [8:0]        data_q, data_d;
  logic              c_q, c_d;
  logic [ID_W-1:0]   oid_q, oid_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic              sa_sel;
  logic [7:0]        a_sel;
  logic [7:0]        b_sel;

  logic [8:0]        sum;
  logic              sum_c;

`ifdef ADDER_ARB_RR_EN
  logic [ID_W-1:0]   ptr_q, ptr_d;

  // Scan upward from the pointer with wrap; first set request wins.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    sa_sel = 1'b0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && iReq[idx]) begin
        found  = 1'b1;
        win    = ID_W'(idx);
        sa_sel = iSA[idx];
        a_sel  = iData_a[8*idx +: 8];
        b_sel  = iData_b[8*idx +: 8];
      end
    end
  end
`else
  // Descending scan so the lowest set index is the last to overwrite.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    sa_sel = 1'b0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (iReq[i]) begin
        found  = 1'b1;
        win    = ID_W'(i);
        sa_sel = iSA[i];
        a_sel  = iData_a[8*i +: 8];
        b_sel  = iData_b[8*i +: 8];
      end
    end
  end
`endif

  // The shared adder only ever sees the latched operands.
  Adder u_adder (
    .iSA     (sa_q),
    .iData_a (a_q),
    .iData_b (b_q),
    .oData   (sum),
    .oData_C (sum_c)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    c_d     = c_q;
    oid_d   = oid_q;
`ifdef ADDER_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sa_d    = sa_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = win;
          gnt_d   = NREQ'(1) << win;
          state_d = CALC;
`ifdef ADDER_ARB_RR_EN
          ptr_d   = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      CALC: begin
        data_d  = sum;
        c_d     = sum_c;
        oid_d   = id_q;
        valid_d = 1'b1;
        gnt_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      sa_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      c_q     <= 1'b0;
      oid_q   <= '0;
`ifdef ADDER_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      c_q     <= c_d;
      oid_q   <= oid_d;
`ifdef ADDER_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign oGnt    = gnt_q;
  assign oValid  = valid_q;
  assign oData   = data_q;
  assign oData_C = c_q;
  assign oId     = oid_q;
  assign oBusy   = (state_q != IDLE);

endmodule
